// File: rtl/cam_pack_multibank.sv
// Camera capture front-end: synchronises a parallel camera bus into WBs_CLK_i, packs pixels into words
// and spreads them over NUM_BANKS FIFOs in BANK_WORDS chunks. Optional CAM_PACK_PAD_EN pushes padded partial words.
module cam_pack_multibank #(
    parameter int DATA_W       = 8,
    parameter int PIX_PER_WORD = 4,
    parameter int NUM_BANKS    = 2,
    parameter int BANK_WORDS   = 512,
    parameter int CNT_W        = 16,
    localparam int WORD_W      = DATA_W * PIX_PER_WORD,
    localparam int SEL_W       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_i,
    input  logic                 Cam_En_i,
    input  logic                 PCLK_i,
    input  logic                 VSYNC_i,
    input  logic                 HREF_i,
    input  logic [DATA_W-1:0]    PIXD_i,
    input  logic [NUM_BANKS-1:0] Bank_Full_i,
    input  logic                 Ovf_Clr_i,
    output logic [NUM_BANKS-1:0] Push_o,
    output logic [WORD_W-1:0]    Push_Data_o,
    output logic [SEL_W-1:0]     Bank_Sel_o,
    output logic [CNT_W-1:0]     Word_Cnt_o,
    output logic                 Frame_Done_o,
    output logic                 Overflow_o,
    output logic                 Busy_o
);

    // state  | meaning
    // IDLE   | waiting for enable and a VSYNC rising edge
    // ACTIVE | packing pixels on sample events
    // FLUSH  | one-cycle end of frame, Frame_Done_o (and padded push) here
    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

    localparam int PC_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int BW_W = $clog2(BANK_WORDS + 1);

    state_t state_q, state_d;
    logic   go_active, go_flush;

    logic pclk_s1, pclk_s2, pclk_s3;
    logic vsync_s1, vsync_s2, vsync_s3;
    logic href_s1, href_s2;
    logic [DATA_W-1:0] pixd_s1, pixd_s2;

    logic              sample_q;
    logic [DATA_W-1:0] pix_q;

    logic [WORD_W-1:0] acc, acc_next;
    logic [PC_W-1:0]   pix_cnt, cnt_next;
    logic [BW_W-1:0]   bank_left;
    logic              pix_ok, word_done, pad_push, push_req;
    logic              vs_rise, vs_fall;

    assign vs_rise = vsync_s2 & ~vsync_s3;
    assign vs_fall = ~vsync_s2 & vsync_s3;
    assign Busy_o  = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        go_active = 1'b0;
        go_flush  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Cam_En_i && vs_rise) begin
                    state_d   = ACTIVE;
                    go_active = 1'b1;
                end
            end
            ACTIVE: begin
                if (!Cam_En_i) begin
                    state_d = IDLE;
                end else if (vs_fall) begin
                    state_d  = FLUSH;
                    go_flush = 1'b1;
                end
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // First pixel of a word lands in the MSBs; the accumulator is cleared per word so
    // any unfilled slots of a partial word are already zero padding.
    always_comb begin
        pix_ok    = (state_q == ACTIVE) && Cam_En_i && sample_q;
        word_done = pix_ok && (pix_cnt == PC_W'(PIX_PER_WORD - 1));
        acc_next  = acc;
        for (int i = 0; i < PIX_PER_WORD; i++) begin
            if (pix_ok && (pix_cnt == PC_W'(i)))
                acc_next[WORD_W-1-i*DATA_W -: DATA_W] = pix_q;
        end
        if (!pix_ok)
            cnt_next = pix_cnt;
        else if (word_done)
            cnt_next = '0;
        else
            cnt_next = pix_cnt + 1'b1;
    end

`ifdef CAM_PACK_PAD_EN
    assign pad_push = go_flush && (cnt_next != '0);
`else
    assign pad_push = 1'b0;
`endif

    assign push_req = word_done | pad_push;

    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) begin
            pclk_s1      <= 1'b0;
            pclk_s2      <= 1'b0;
            pclk_s3      <= 1'b0;
            vsync_s1     <= 1'b0;
            vsync_s2     <= 1'b0;
            vsync_s3     <= 1'b0;
            href_s1      <= 1'b0;
            href_s2      <= 1'b0;
            pixd_s1      <= '0;
            pixd_s2      <= '0;
            sample_q     <= 1'b0;
            pix_q        <= '0;
            state_q      <= IDLE;
            acc          <= '0;
            pix_cnt      <= '0;
            bank_left    <= BW_W'(BANK_WORDS - 1);
            Push_o       <= '0;
            Push_Data_o  <= '0;
            Bank_Sel_o   <= '0;
            Word_Cnt_o   <= '0;
            Frame_Done_o <= 1'b0;
            Overflow_o   <= 1'b0;
        end else begin
            pclk_s1  <= PCLK_i;
            pclk_s2  <= pclk_s1;
            pclk_s3  <= pclk_s2;
            vsync_s1 <= VSYNC_i;
            vsync_s2 <= vsync_s1;
            vsync_s3 <= vsync_s2;
            href_s1  <= HREF_i;
            href_s2  <= href_s1;
            pixd_s1  <= PIXD_i;
            pixd_s2  <= pixd_s1;

            // Registered edge detect keeps the pixel aligned with its sample strobe.
            sample_q <= pclk_s2 & ~pclk_s3 & vsync_s2 & href_s2;
            pix_q    <= pixd_s2;

            state_q      <= state_d;
            Push_o       <= '0;
            Frame_Done_o <= go_flush;

            if (state_d == ACTIVE) begin
                acc     <= word_done ? '0 : acc_next;
                pix_cnt <= cnt_next;
            end else begin
                acc     <= '0;
                pix_cnt <= '0;
            end

            if (Ovf_Clr_i)
                Overflow_o <= 1'b0;

            if (go_active) begin
                Word_Cnt_o <= '0;
                Bank_Sel_o <= '0;
                bank_left  <= BW_W'(BANK_WORDS - 1);
            end else if (push_req) begin
                if (Bank_Full_i[Bank_Sel_o]) begin
                    Overflow_o <= 1'b1;
                end else begin
                    Push_o      <= NUM_BANKS'(1) << Bank_Sel_o;
                    Push_Data_o <= acc_next;
                    if (Word_Cnt_o != {CNT_W{1'b1}})
                        Word_Cnt_o <= Word_Cnt_o + 1'b1;
                    if (bank_left == '0) begin
                        bank_left  <= BW_W'(BANK_WORDS - 1);
                        Bank_Sel_o <= (Bank_Sel_o == SEL_W'(NUM_BANKS - 1)) ? '0 : Bank_Sel_o + 1'b1;
                    end else begin
                        bank_left <= bank_left - 1'b1;
                    end
                end
            end
        end
    end

endmodule
